// File: rtl/serial_crc_ccitt_checker.sv
// Serial CRC-CCITT frame checker.
// A frame is PAYLOAD_BITS payload bits followed by 16 CRC bits, MSB first.
// The LFSR (poly 0x1021, init 0xFFFF, unreflected, no final XOR) runs over
// payload and CRC bits. A correct frame leaves a zero residue. crc_calc
// captures the LFSR value at the payload/CRC boundary.
// Optional feature: define CRC_CHECK_STATS_EN to enable the saturating
// good/bad frame counters. Without it both counters are tied to zero.
module serial_crc_ccitt_checker #(
  parameter int PAYLOAD_BITS = 72
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        enable,
  input  logic        data_in,
  output logic        busy,
  output logic        done,
  output logic        crc_ok,
  output logic        crc_err,
  output logic [15:0] crc_calc,
  output logic [15:0] good_count,
  output logic [15:0] bad_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    CRC     = 2'd2,
    REPORT  = 2'd3
  } state_t;

  localparam logic [15:0] LAST_PAYLOAD = 16'(PAYLOAD_BITS - 1);
  localparam logic [15:0] LAST_CRC     = 16'd15;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] lfsr;
  logic [15:0] lfsr_nxt;
  logic [15:0] bit_cnt;
  logic        consume;
  logic        last_payload;
  logic        last_crc;

  // One serial LFSR step, MSB-first CRC-CCITT.
  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic d);
    logic fb;
    fb = c[15] ^ d;
    return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  // A start in the same cycle always wins over the data bit.
  assign consume      = enable && !start && ((state == PAYLOAD) || (state == CRC));
  assign last_payload = consume && (state == PAYLOAD) && (bit_cnt == LAST_PAYLOAD);
  assign last_crc     = consume && (state == CRC) && (bit_cnt == LAST_CRC);
  assign lfsr_nxt     = crc_step(lfsr, data_in);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; start restarts the frame from any state.
  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = PAYLOAD;
    end else begin
      case (state)
        PAYLOAD: if (last_payload) state_nxt = CRC;
        CRC:     if (last_crc)     state_nxt = REPORT;
        REPORT:  state_nxt = IDLE;
        default: state_nxt = state;
      endcase
    end
  end

  // Output decode.
  always_comb begin
    busy = (state != IDLE);
  end

  // LFSR, bit counter and verdict registers. The verdict is latched on the
  // last CRC bit edge so it is valid alongside done in the REPORT cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr     <= 16'hFFFF;
      bit_cnt  <= 16'd0;
      crc_calc <= 16'h0000;
      done     <= 1'b0;
      crc_ok   <= 1'b0;
      crc_err  <= 1'b0;
    end else begin
      done <= last_crc;
      if (start) begin
        lfsr    <= 16'hFFFF;
        bit_cnt <= 16'd0;
        crc_ok  <= 1'b0;
        crc_err <= 1'b0;
      end else if (consume) begin
        lfsr <= lfsr_nxt;
        if (last_payload) begin
          bit_cnt  <= 16'd0;
          crc_calc <= lfsr_nxt;
        end else if (last_crc) begin
          bit_cnt <= 16'd0;
          crc_ok  <= (lfsr_nxt == 16'h0000);
          crc_err <= (lfsr_nxt != 16'h0000);
        end else begin
          bit_cnt <= bit_cnt + 16'd1;
        end
      end
    end
  end

`ifdef CRC_CHECK_STATS_EN
  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Frame statistics, updated when a frame completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      good_count <= 16'd0;
      bad_count  <= 16'd0;
    end else if (last_crc) begin
      if (lfsr_nxt == 16'h0000) begin
        good_count <= sat_inc(good_count);
      end else begin
        bad_count <= sat_inc(bad_count);
      end
    end
  end
`else
  assign good_count = 16'd0;
  assign bad_count  = 16'd0;
`endif

endmodule

// File: tb/tb_serial_crc_ccitt_checker.sv
// Directed testbench for serial_crc_ccitt_checker with a result scoreboard.
module tb_serial_crc_ccitt_checker;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        enable;
  logic        data_in;
  logic        busy;
  logic        done;
  logic        crc_ok;
  logic        crc_err;
  logic [15:0] crc_calc;
  logic [15:0] good_count;
  logic [15:0] bad_count;

  typedef struct {
    logic        ok;
    logic [15:0] calc;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   done_cnt = 0;

  serial_crc_ccitt_checker #(.PAYLOAD_BITS(72)) dut (
    .clk(clk), .reset(reset), .start(start), .enable(enable), .data_in(data_in),
    .busy(busy), .done(done), .crc_ok(crc_ok), .crc_err(crc_err),
    .crc_calc(crc_calc), .good_count(good_count), .bad_count(bad_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Bit-serial reference CRC over a 72-bit payload, MSB first.
  function automatic logic [15:0] model_crc(input logic [71:0] p);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    for (int i = 71; i >= 0; i--) begin
      fb = c[15] ^ p[i];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ 16'h1021;
    end
    return c;
  endfunction

  // Scoreboard consumer: every done pulse pops and checks one expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      exp_t e;
      done_cnt++;
      if (sb.size() == 0) begin
        chk("unexpected_done", 16'd1, 16'd0);
      end else begin
        e = sb.pop_front();
        chk("crc_ok",   {15'd0, crc_ok},  {15'd0, e.ok});
        chk("crc_err",  {15'd0, crc_err}, {15'd0, ~e.ok});
        chk("crc_calc", crc_calc, e.calc);
      end
    end
  end

  task automatic step(input logic s, input logic e, input logic d);
    start   = s;
    enable  = e;
    data_in = d;
    @(posedge clk);
    #1;
  endtask

  // Start cycle carries enable=1 and data=1 to show the bit is ignored.
  task automatic run_frame(input logic [87:0] fr, input bit alt,
                           input logic ok, input logic [15:0] calc);
    exp_t e;
    int   k;
    e.ok   = ok;
    e.calc = calc;
    sb.push_back(e);
    step(1'b1, 1'b1, 1'b1);
    for (int i = 87; i >= 0; i--) begin
      if (alt) step(1'b0, 1'b0, ~fr[i]);
      step(1'b0, 1'b1, fr[i]);
    end
    k = 0;
    while (sb.size() != 0 && k < 8) begin
      step(1'b0, 1'b0, 1'b0);
      k++;
    end
    chk("done_within_bound", 16'(sb.size()), 16'd0);
  endtask

  logic [71:0] pay;
  logic [71:0] bad_pay;
  logic [87:0] good_fr;
  logic [87:0] bad_fr;
  logic [87:0] badcrc_fr;
  logic [15:0] bad_crc;
  int          d0;

  initial begin
    pay       = "123456789";
    good_fr   = {pay, 16'h29B1};
    bad_pay   = pay;
    bad_pay[71] = ~bad_pay[71];
    bad_fr    = {bad_pay, 16'h29B1};
    bad_crc   = model_crc(bad_pay);
    badcrc_fr = {pay, 16'h29B0};

    reset = 1'b1; start = 1'b0; enable = 1'b0; data_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    // Reset values, sampled while reset is still asserted.
    chk("rst_busy",  {15'd0, busy},    16'd0);
    chk("rst_done",  {15'd0, done},    16'd0);
    chk("rst_ok",    {15'd0, crc_ok},  16'd0);
    chk("rst_err",   {15'd0, crc_err}, 16'd0);
    chk("rst_calc",  crc_calc,   16'h0000);
    chk("rst_good",  good_count, 16'd0);
    chk("rst_bad",   bad_count,  16'd0);
    reset = 1'b0;
    step(1'b0, 1'b0, 1'b0);

    // Check-value frame, enable held high.
    d0 = done_cnt;
    run_frame(good_fr, 1'b0, 1'b1, 16'h29B1);
    chk("good_done_once", 16'(done_cnt - d0), 16'd1);
    chk("good_idle_busy", {15'd0, busy}, 16'd0);
    step(1'b0, 1'b0, 1'b0);
    chk("ok_holds", {15'd0, crc_ok}, 16'd1);

    // First payload bit inverted.
    run_frame(bad_fr, 1'b0, 1'b0, bad_crc);
    chk("bad_calc_differs", {15'd0, (crc_calc == 16'h29B1)}, 16'd0);

    // Alternate-cycle enable gives identical results.
    d0 = done_cnt;
    run_frame(good_fr, 1'b1, 1'b1, 16'h29B1);
    chk("alt_done_once", 16'(done_cnt - d0), 16'd1);

    // Abort after 40 bits, then a full valid frame.
    d0 = done_cnt;
    step(1'b1, 1'b0, 1'b0);
    chk("busy_after_start", {15'd0, busy}, 16'd1);
    chk("start_clears_ok", {15'd0, crc_ok}, 16'd0);
    for (int i = 87; i > 47; i--) step(1'b0, 1'b1, bad_fr[i]);
    run_frame(good_fr, 1'b0, 1'b1, 16'h29B1);
    chk("abort_done_once", 16'(done_cnt - d0), 16'd1);

    // Reset mid-frame discards the frame.
    d0 = done_cnt;
    step(1'b1, 1'b0, 1'b0);
    for (int i = 87; i > 57; i--) step(1'b0, 1'b1, good_fr[i]);
    reset = 1'b1;
    step(1'b0, 1'b1, 1'b1);
    reset = 1'b0;
    chk("midrst_busy", {15'd0, busy}, 16'd0);
    chk("midrst_calc", crc_calc, 16'h0000);
    repeat (100) step(1'b0, 1'b1, 1'b0);
    chk("midrst_no_done", 16'(done_cnt - d0), 16'd0);
    chk("midrst_busy_idle", {15'd0, busy}, 16'd0);

    // Statistics: three good and two bad frames since the reset.
    run_frame(good_fr,   1'b0, 1'b1, 16'h29B1);
    run_frame(bad_fr,    1'b0, 1'b0, bad_crc);
    run_frame(good_fr,   1'b1, 1'b1, 16'h29B1);
    run_frame(badcrc_fr, 1'b0, 1'b0, 16'h29B1);
    run_frame(good_fr,   1'b0, 1'b1, 16'h29B1);
`ifdef CRC_CHECK_STATS_EN
    chk("good_count", good_count, 16'd3);
    chk("bad_count",  bad_count,  16'd2);
`else
    chk("good_count", good_count, 16'd0);
    chk("bad_count",  bad_count,  16'd0);
`endif
    chk("sb_empty", 16'(sb.size()), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
